// File: rtl/iddr_rx_framer.sv
// ============================================================================
// iddr_rx_framer : DDR input capture, preamble/SFD strip, framed word stream
// Optional feature macro: IDDR_RX_STATS_EN (adds stat_good/stat_bad/stat_abort)
// Revision: 1.0
// ============================================================================
`default_nettype none

module iddr_rx_framer #(
  parameter int unsigned        WIDTH          = 4,
  parameter bit                 STRIP_PREAMBLE = 1'b1,
  parameter logic [2*WIDTH-1:0] PRE_WORD       = 8'h55,
  parameter logic [2*WIDTH-1:0] SFD_WORD       = 8'hD5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     d,
  input  logic                 ctl,
  output logic [2*WIDTH-1:0]   m_data,
  output logic                 m_valid,
  output logic                 m_last,
  output logic                 m_error,
  output logic [15:0]          m_len,
`ifdef IDDR_RX_STATS_EN
  output logic [31:0]          stat_good,
  output logic [31:0]          stat_bad,
  output logic [31:0]          stat_abort,
`endif
  output logic                 rx_frame_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_DROP = 2'd3
  } state_t;

  logic [WIDTH-1:0]   rise_d_q, fall_d_q;
  logic               rise_ctl_q, fall_ctl_q;
  logic [2*WIDTH-1:0] word_q, hold_q;
  logic               word_dv_q, word_er_q, hold_dv_q, hold_er_q;

  state_t             state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic               err_q, err_d;
  logic [2*WIDTH-1:0] m_data_q, m_data_d;
  logic               m_valid_q, m_valid_d;
  logic               m_last_q, m_last_d;
  logic               m_error_q, m_error_d;
  logic [15:0]        m_len_q, m_len_d;
  logic               frame_err_q, frame_err_d;
  logic               emit;
  logic [15:0]        len_inc;
  logic               err_acc;

  // Rising-edge sample, then word assembly and one hold stage so the
  // successor's dv is known when the held word is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_d_q   <= '0;
      rise_ctl_q <= 1'b0;
      word_q     <= '0;
      word_dv_q  <= 1'b0;
      word_er_q  <= 1'b0;
      hold_q     <= '0;
      hold_dv_q  <= 1'b0;
      hold_er_q  <= 1'b0;
    end else begin
      rise_d_q   <= d;
      rise_ctl_q <= ctl;
      word_q     <= {fall_d_q, rise_d_q};
      word_dv_q  <= rise_ctl_q;
      word_er_q  <= rise_ctl_q ^ fall_ctl_q;
      hold_q     <= word_q;
      hold_dv_q  <= word_dv_q;
      hold_er_q  <= word_er_q;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fall_d_q   <= '0;
      fall_ctl_q <= 1'b0;
    end else begin
      fall_d_q   <= d;
      fall_ctl_q <= ctl;
    end
  end

  assign len_inc = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
  assign err_acc = err_q | hold_er_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    err_d       = err_q;
    m_data_d    = '0;
    m_valid_d   = 1'b0;
    m_last_d    = 1'b0;
    m_error_d   = 1'b0;
    m_len_d     = 16'd0;
    frame_err_d = 1'b0;
    emit        = 1'b0;

    case (state_q)
      S_IDLE: begin
        len_d = 16'd0;
        err_d = 1'b0;
        if (hold_dv_q) begin
          if (STRIP_PREAMBLE) begin
            state_d = S_PRE;
          end else begin
            state_d = S_DATA;
            emit    = 1'b1;
          end
        end
      end
      S_PRE: begin
        if (!hold_dv_q) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else if (hold_q == SFD_WORD) begin
          state_d = S_DATA;
        end else if (hold_q != PRE_WORD) begin
          state_d = S_DROP;
        end
      end
      S_DATA: begin
        if (hold_dv_q) begin
          emit = 1'b1;
        end else begin
          // SFD directly followed by dv=0: empty frame, nothing to report
          state_d = S_IDLE;
          len_d   = 16'd0;
          err_d   = 1'b0;
        end
      end
      default: begin
        if (!hold_dv_q) begin
          state_d = S_IDLE;
        end
      end
    endcase

    if (emit) begin
      m_valid_d = 1'b1;
      m_data_d  = hold_q;
      len_d     = len_inc;
      err_d     = err_acc;
      if (!word_dv_q) begin
        m_last_d  = 1'b1;
        m_len_d   = len_inc;
        m_error_d = err_acc;
        len_d     = 16'd0;
        err_d     = 1'b0;
        state_d   = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= 16'd0;
      err_q       <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_error_q   <= 1'b0;
      m_len_q     <= 16'd0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      err_q       <= err_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_error_q   <= m_error_d;
      m_len_q     <= m_len_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign m_data       = m_data_q;
  assign m_valid      = m_valid_q;
  assign m_last       = m_last_q;
  assign m_error      = m_error_q;
  assign m_len        = m_len_q;
  assign rx_frame_err = frame_err_q;

`ifdef IDDR_RX_STATS_EN
  logic [31:0] stat_good_q, stat_good_d;
  logic [31:0] stat_bad_q, stat_bad_d;
  logic [31:0] stat_abort_q, stat_abort_d;
  logic        drop_enter;

  assign drop_enter = (state_q == S_PRE) && (state_d == S_DROP);

  always_comb begin
    stat_good_d  = stat_good_q  + {31'd0, m_last_d & ~m_error_d};
    stat_bad_d   = stat_bad_q   + {31'd0, m_last_d &  m_error_d};
    stat_abort_d = stat_abort_q + {31'd0, frame_err_d | drop_enter};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_good_q  <= 32'd0;
      stat_bad_q   <= 32'd0;
      stat_abort_q <= 32'd0;
    end else begin
      stat_good_q  <= stat_good_d;
      stat_bad_q   <= stat_bad_d;
      stat_abort_q <= stat_abort_d;
    end
  end

  assign stat_good  = stat_good_q;
  assign stat_bad   = stat_bad_q;
  assign stat_abort = stat_abort_q;
`endif

endmodule

`default_nettype wire
